// File: rtl/demux_rr_sched.sv
// demux_rr_sched
// Round-robin scheduler for a 1-to-8 demultiplexer fed by one valid/ready
// stream. It holds one word at a time, steers it to the next enabled
// channel after the last one served, and waits for that channel's ready.
// A word whose channel never accepts it within TIMEOUT cycles is dropped,
// so a stalled channel cannot lock up the shared path.
//
// Parameters
//   WIDTH    data word width
//   TIMEOUT  cycles a held word may wait before it is dropped (0 = never)
// Ports
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_valid   upstream word present
//   in_data    upstream word
//   in_ready   word accepted this cycle (combinational)
//   en_mask    per-channel enables, sampled only when a word is accepted
//   out_ready  per-channel ready
//   sel        demux select of the channel holding the current word
//   out_valid  one-hot valid on channel sel while a word is held
//   out_data   held word, shared by all channels
//   busy       a word is held
//   drop       one-cycle pulse after a word is discarded by timeout
//   drop_cnt   saturating count of dropped words
module demux_rr_sched #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [7:0]       en_mask,
  input  logic [7:0]       out_ready,
  output logic [2:0]       sel,
  output logic [7:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             drop,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  ptr;
  logic [15:0] cnt;

  logic        complete;
  logic        timeout_hit;
  logic        accept;
  logic [2:0]  base;
  logic [2:0]  next_ch;
  logic [2:0]  idx;
  logic        found;

  always_comb begin
    complete    = (state == S_WAIT) && out_ready[sel];
    timeout_hit = (state == S_WAIT) && !complete && (TIMEOUT != 0) &&
                  (cnt == TO_LAST);
    in_ready    = (en_mask != '0) && ((state == S_IDLE) || complete);
    accept      = in_valid && in_ready;
    busy        = (state == S_WAIT);
    out_valid   = (state == S_WAIT) ? (8'(1) << sel) : '0;

    // A word completing this cycle counts as served before the search for
    // the next destination, so back-to-back words keep rotating.
    base    = complete ? sel : ptr;
    next_ch = base;
    idx     = base;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = 3'(base + 3'(i));
      if (!found && en_mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end

    state_nxt = state;
    if (accept) begin
      state_nxt = S_WAIT;
    end else if (complete || timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 3'd7;
      sel      <= '0;
      out_data <= '0;
      cnt      <= '0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= timeout_hit;
      if (timeout_hit && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if (complete || timeout_hit) begin
        ptr <= sel;
      end
      if (accept) begin
        out_data <= in_data;
        sel      <= next_ch;
        cnt      <= '0;
      end else if ((state == S_WAIT) && !complete && !timeout_hit) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed testbench for demux_rr_sched. Two instances share all inputs:
// dut uses TIMEOUT = 16, dut4 uses TIMEOUT = 4 for the drop scenarios.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] en_mask;
  logic [7:0] out_ready;

  logic       in_ready,  in_ready4;
  logic [2:0] sel,       sel4;
  logic [7:0] out_valid, out_valid4;
  logic [7:0] out_data,  out_data4;
  logic       busy,      busy4;
  logic       drop,      drop4;
  logic [7:0] drop_cnt,  drop_cnt4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  demux_rr_sched #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en_mask(en_mask), .out_ready(out_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .drop(drop), .drop_cnt(drop_cnt)
  );

  demux_rr_sched #(.WIDTH(8), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .en_mask(en_mask), .out_ready(out_ready),
    .sel(sel4), .out_valid(out_valid4), .out_data(out_data4), .busy(busy4),
    .drop(drop4), .drop_cnt(drop_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    en_mask   = '0;
    out_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] mseq [6];
    logic       drop_seen;
    mseq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_sel",      32'(sel),       32'd0);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_data",     32'(out_data),  32'd0);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_drop",     32'(drop),      32'd0);
    check("rst_dropcnt",  32'(drop_cnt),  32'd0);
    check("rst_inready",  32'(in_ready),  32'd0);
    tick();

    // Round robin over all channels, one word per cycle
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_data  = 8'(8'h10 + k);
      @(negedge clk);
      if (k > 0) begin
        check("rr_sel",   32'(sel),       32'(k - 1));
        check("rr_valid", 32'(out_valid), 32'(8'h01 << (k - 1)));
        check("rr_data",  32'(out_data),  32'(8'h10 + k - 1));
      end
      if (k < 8) check("rr_inready", 32'(in_ready), 32'd1);
      tick();
    end
    @(negedge clk);
    check("rr_idle_busy",  32'(busy),      32'd0);
    check("rr_idle_valid", 32'(out_valid), 32'd0);
    check("rr_idle_sel",   32'(sel),       32'd7);

    // Masked skip: only channels 2, 5, 7 enabled
    do_reset();
    en_mask   = 8'b1010_0100;
    out_ready = 8'hFF;
    for (int k = 0; k <= 6; k++) begin
      in_valid = (k < 6);
      in_data  = 8'(8'h20 + k);
      @(negedge clk);
      if (k > 0) begin
        check("mask_sel",   32'(sel),       32'(mseq[k-1]));
        check("mask_valid", 32'(out_valid), 32'(8'h01 << mseq[k-1]));
      end
      tick();
    end

    // Backpressure on channel 0 for 5 cycles, handshake on the 6th
    do_reset();
    en_mask   = 8'hFF;
    out_ready = 8'hFE;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    tick();
    in_data   = 8'h31;
    drop_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      out_ready = (c == 6) ? 8'hFF : 8'hFE;
      @(negedge clk);
      check("bp_sel",     32'(sel),       32'd0);
      check("bp_valid",   32'(out_valid), 32'h01);
      check("bp_inready", 32'(in_ready),  32'(c == 6));
      if (drop) drop_seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_sel",   32'(sel),       32'd1);
    check("bp_next_valid", 32'(out_valid), 32'h02);
    check("bp_next_data",  32'(out_data),  32'h31);
    if (drop) drop_seen = 1'b1;
    check("bp_no_drop",    32'(drop_seen), 32'd0);
    tick();

    // Timeout with TIMEOUT = 4 (dut4)
    do_reset();
    en_mask   = 8'hFF;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    @(negedge clk);
    check("to_inready", 32'(in_ready4), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("to_valid", 32'(out_valid4), 32'h01);
      check("to_drop0", 32'(drop4),      32'd0);
      if (c == 4) check("to_inready_discard", 32'(in_ready4), 32'd0);
      tick();
    end
    @(negedge clk);
    check("to_valid_off", 32'(out_valid4), 32'd0);
    check("to_busy_off",  32'(busy4),      32'd0);
    check("to_drop",      32'(drop4),      32'd1);
    check("to_dropcnt",   32'(drop_cnt4),  32'd1);
    tick();
    in_valid = 1'b1;
    in_data  = 8'hBB;
    @(negedge clk);
    check("to_drop_pulse", 32'(drop4),     32'd0);
    check("to_inready2",   32'(in_ready4), 32'd1);
    tick();
    @(negedge clk);
    check("to_next_sel",   32'(sel4),       32'd1);
    check("to_next_valid", 32'(out_valid4), 32'h02);
    check("to_next_data",  32'(out_data4),  32'hBB);
    // Each drop takes 5 cycles; 1600 cycles yields well over 255 drops
    for (int c = 0; c < 1600; c++) tick();
    @(negedge clk);
    check("to_dropcnt_sat", 32'(drop_cnt4), 32'd255);

    // Reset while holding a word on channel 4
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    en_mask  = 8'h10;
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_sel",        32'(sel),             32'd4);
    check("mr_busy",       32'(busy),            32'd1);
    check("mr_dropcnt_nz", 32'(drop_cnt != 8'd0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid",    32'(out_valid),  32'd0);
    check("mr_busy0",    32'(busy),       32'd0);
    check("mr_sel0",     32'(sel),        32'd0);
    check("mr_dropcnt",  32'(drop_cnt),   32'd0);
    check("mr_drop",     32'(drop),       32'd0);
    check("mr_dropcnt4", 32'(drop_cnt4),  32'd0);
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_first_sel",   32'(sel),       32'd0);
    check("mr_first_valid", 32'(out_valid), 32'h01);
    tick();

    // Mask edge cases
    do_reset();
    en_mask  = 8'h00;
    in_valid = 1'b1;
    in_data  = 8'h44;
    @(negedge clk);
    check("m0_inready", 32'(in_ready), 32'd0);
    check("m0_busy",    32'(busy),     32'd0);
    tick();
    @(negedge clk);
    check("m0_busy_after", 32'(busy), 32'd0);
    en_mask   = 8'h08;
    out_ready = 8'h00;
    in_data   = 8'h55;
    tick();
    en_mask  = 8'h00;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mc_sel",     32'(sel),       32'd3);
      check("mc_valid",   32'(out_valid), 32'h08);
      check("mc_inready", 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 8'h08;
    @(negedge clk);
    check("mc_deliver_valid", 32'(out_valid), 32'h08);
    check("mc_deliver_data",  32'(out_data),  32'h55);
    tick();
    @(negedge clk);
    check("mc_done_busy", 32'(busy), 32'd0);
    check("mc_done_drop", 32'(drop), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that feeds a 1-to-8 demultiplexer from a single valid/ready input stream. It holds one word, picks the next enabled destination channel, drives the 3-bit select and a one-hot valid toward that channel, and waits for the channel's ready. A per-word timeout drops words that a stalled channel never accepts, so the shared demux path cannot lock up. It sits between the upstream stream source and the demux/output fan-out.

## Interface
- WIDTH, 8: data word width.
- TIMEOUT, 16: cycles a held word waits for its channel before it is dropped; 0 disables the timeout. Range 0..65535.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  block accepts in_data this cycle (combinational).
- en_mask  in  8  channel enables, bit i = channel i.
- out_ready  in  8  per-channel ready.
- sel  out  3  demux select; index of the channel holding the current word.
- out_valid  out  8  one-hot valid, bit sel set while a word is held; else 0.
- out_data  out  WIDTH  held word, shared by all channels.
- busy  out  1  word held (state WAIT).
- drop  out  1  one-cycle pulse: a word was discarded by timeout.
- drop_cnt  out  8  saturating count of dropped words.

## Operation
- State machine states: IDLE (no word held) and WAIT (word held).
- Round-robin pointer ptr (3 bits) holds the last channel served or dropped.
- next_ch is the first set bit of en_mask at or after ptr+1 (mod 8), searching upward with wrap. It is valid only when en_mask != 0.
- Accept condition: in_valid && in_ready.
- in_ready = (en_mask != 0) && (state == IDLE || complete), where complete = out_ready[sel] in WAIT.
- On accept:
  - out_data <= in_data.
  - sel <= next_ch, computed with ptr already updated to the completing channel when complete is true in the same cycle.
  - Timeout counter <= 0; state <= WAIT.
- WAIT, complete: ptr <= sel. If a new word is accepted in the same cycle, stay in WAIT; otherwise go to IDLE.
- WAIT, no complete, TIMEOUT != 0, counter == TIMEOUT-1:
  - Word is discarded; ptr <= sel; state <= IDLE.
  - Next cycle drop = 1. drop_cnt increments and saturates at 255.
  - in_ready is 0 in the discard cycle.
- WAIT, otherwise: counter increments.
- en_mask is sampled only at accept. Changing it during WAIT does not move or cancel the held word.
- en_mask == 0: in_ready = 0. Any held word still completes or times out normally.
- sel holds its last value in IDLE.
- out_data is don't-care when out_valid == 0, but it holds its last value.

## Timing
- Reset values: state IDLE, ptr = 7 (first served channel is the lowest enabled channel ≥ 0), sel = 0, out_valid = 0, out_data = 0, busy = 0, drop = 0, drop_cnt = 0, counter = 0.
- Latency: a word accepted at edge N drives out_valid/out_data/sel from cycle N+1.
- Throughput: one word per cycle when the target channels are always ready (back-to-back complete + accept).
- Timeout: with TIMEOUT = T, a word accepted at edge N and never readied is discarded at edge N+T. drop is high during cycle N+T+1.
- Handshake completing on the same cycle the counter reaches T-1 counts as complete; no drop.
- Reset mid-WAIT discards the held word without a drop pulse and returns every register to its reset value.

## Test plan
- Round-robin: en_mask = 8'hFF, out_ready = 8'hFF, stream 0x10..0x17 back-to-back → sel sequence 0,1,...,7; one word per cycle; out_valid = 8'h01, 8'h02, ..., 8'h80; in_ready stays 1.
- Masked skip: en_mask = 8'b1010_0100, all ready, 6 words → sel sequence 2,5,7,2,5,7; no other out_valid bit ever set.
- Backpressure: en_mask = 8'hFF, out_ready[0] = 0 for 5 cycles, then 1; TIMEOUT = 16 → word held on sel = 0 for 6 cycles; in_ready = 0 until the handshake cycle; next word goes to sel = 1; drop never pulses.
- Timeout: TIMEOUT = 4, out_ready = 0, accept 0xAA at edge N → out_valid = 8'h01 for cycles N+1..N+4, then 0; drop = 1 in cycle N+5; drop_cnt = 1; next word goes to channel 1. Repeat 300 drops → drop_cnt = 255.
- Mask edge cases: en_mask = 0 with in_valid = 1 → in_ready = 0, busy = 0. Clear en_mask during WAIT on channel 3 → word still delivered on sel = 3 when out_ready[3] rises.
- Reset mid-operation: assert rst in WAIT with sel = 4 → next cycle out_valid = 0, busy = 0, sel = 0, drop_cnt = 0. First word after reset goes to channel 0 with en_mask = 8'hFF.
